// File: rtl/issue_queue_if.sv
// Dispatch, wakeup and FU-issue signals of the issue queue, bundled as one
// interface. The queue uses the slave modport; the producer/consumer side
// (rename stage, FU, result bus) uses the master modport.
interface issue_queue_if #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
);
    // dispatch side
    logic                        in_valid;
    logic                        in_ready;
    logic [3:0]                  in_ALUControl;
    logic                        in_ALUSrc;
    logic                        in_is_for_lsq;
    logic [DATA_W-1:0]           in_imm;
    logic                        in_rs1_ready;
    logic                        in_rs2_ready;
    logic [TAG_W-1:0]            in_rs1_tag;
    logic [TAG_W-1:0]            in_rs2_tag;
    logic [DATA_W-1:0]           in_rs1_value;
    logic [DATA_W-1:0]           in_rs2_value;
    logic [TAG_W-1:0]            in_dest_tag;
    logic [TAG_W-1:0]            in_rob_index;
    // result broadcast
    logic                        wakeup_active;
    logic [TAG_W-1:0]            wakeup_tag;
    logic [DATA_W-1:0]           wakeup_value;
    // FU issue side
    logic                        fu_is_available;
    logic                        fu_write_enable;
    logic [3:0]                  fu_ALUControl;
    logic                        fu_ALUSrc;
    logic                        fu_is_for_lsq;
    logic [DATA_W-1:0]           fu_imm;
    logic [DATA_W-1:0]           fu_rs1_value;
    logic [DATA_W-1:0]           fu_rs2_value;
    logic [TAG_W-1:0]            fu_tag_to_output;
    logic [TAG_W-1:0]            fu_rob_index;
    // occupancy
    logic [$clog2(DEPTH+1)-1:0]  count;

    modport master (
        output in_valid, in_ALUControl, in_ALUSrc, in_is_for_lsq, in_imm,
               in_rs1_ready, in_rs2_ready, in_rs1_tag, in_rs2_tag,
               in_rs1_value, in_rs2_value, in_dest_tag, in_rob_index,
               wakeup_active, wakeup_tag, wakeup_value, fu_is_available,
        input  in_ready, fu_write_enable, fu_ALUControl, fu_ALUSrc,
               fu_is_for_lsq, fu_imm, fu_rs1_value, fu_rs2_value,
               fu_tag_to_output, fu_rob_index, count
    );

    modport slave (
        input  in_valid, in_ALUControl, in_ALUSrc, in_is_for_lsq, in_imm,
               in_rs1_ready, in_rs2_ready, in_rs1_tag, in_rs2_tag,
               in_rs1_value, in_rs2_value, in_dest_tag, in_rob_index,
               wakeup_active, wakeup_tag, wakeup_value, fu_is_available,
        output in_ready, fu_write_enable, fu_ALUControl, fu_ALUSrc,
               fu_is_for_lsq, fu_imm, fu_rs1_value, fu_rs2_value,
               fu_tag_to_output, fu_rob_index, count
    );
endinterface

// File: rtl/issue_queue.sv
// Collapsing reservation station for ALU ops. Slot 0 is the oldest entry and
// slots [0, count) are valid. Operands wait for their producer tag on the
// wakeup bus; the oldest fully-ready entry issues whenever the FU is free.
module issue_queue #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    issue_queue_if.slave  q
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SEL_W = $clog2(DEPTH);

    typedef struct packed {
        logic [3:0]        alu_ctrl;
        logic              alu_src;
        logic              is_for_lsq;
        logic [DATA_W-1:0] imm;
        logic              rs1_rdy;
        logic [TAG_W-1:0]  rs1_tag;
        logic [DATA_W-1:0] rs1_val;
        logic              rs2_rdy;
        logic [TAG_W-1:0]  rs2_tag;
        logic [DATA_W-1:0] rs2_val;
        logic [TAG_W-1:0]  dest_tag;
        logic [TAG_W-1:0]  rob_index;
    } entry_t;

    entry_t            slots     [DEPTH];
    entry_t            slots_nxt [DEPTH];
    entry_t            woke      [DEPTH];
    entry_t            new_ent;
    entry_t            issued;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_nxt;
    logic [CNT_W-1:0]  cnt_mid;
    logic [DEPTH-1:0]  rdy;
    logic [SEL_W-1:0]  sel;
    logic              any_rdy;
    logic              issue;
    logic              accept;

    // Mark valid entries whose two operands are both available
    always_comb begin
        rdy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rdy[i] = (CNT_W'(i) < count_r) && slots[i].rs1_rdy && slots[i].rs2_rdy;
        end
    end

    // Pick the lowest-index (oldest) ready entry; defaults to slot 0
    always_comb begin
        sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (rdy[i]) sel = SEL_W'(i);
        end
    end

    assign any_rdy    = |rdy;
    // A flush cycle never issues, so nothing leaves toward the FU on a squash
    assign issue      = q.fu_is_available && any_rdy && !flush;
    // No credit for a same-cycle issue: a full queue refuses dispatch
    assign q.in_ready = (count_r < CNT_W'(DEPTH));
    assign accept     = q.in_valid && q.in_ready;
    assign issued     = slots[sel];

    assign q.fu_write_enable  = issue;
    assign q.fu_ALUControl    = issued.alu_ctrl;
    assign q.fu_ALUSrc        = issued.alu_src;
    assign q.fu_is_for_lsq    = issued.is_for_lsq;
    assign q.fu_imm           = issued.imm;
    assign q.fu_rs1_value     = issued.rs1_val;
    assign q.fu_rs2_value     = issued.rs2_val;
    assign q.fu_tag_to_output = issued.dest_tag;
    assign q.fu_rob_index     = issued.rob_index;
    assign q.count            = count_r;

    // Form the incoming entry, capturing a same-cycle broadcast of its producers
    always_comb begin
        new_ent            = '0;
        new_ent.alu_ctrl   = q.in_ALUControl;
        new_ent.alu_src    = q.in_ALUSrc;
        new_ent.is_for_lsq = q.in_is_for_lsq;
        new_ent.imm        = q.in_imm;
        new_ent.rs1_rdy    = q.in_rs1_ready;
        new_ent.rs1_tag    = q.in_rs1_tag;
        new_ent.rs1_val    = q.in_rs1_value;
        // An immediate rhs never waits on a producer
        new_ent.rs2_rdy    = q.in_rs2_ready || q.in_ALUSrc;
        new_ent.rs2_tag    = q.in_rs2_tag;
        new_ent.rs2_val    = q.in_rs2_value;
        new_ent.dest_tag   = q.in_dest_tag;
        new_ent.rob_index  = q.in_rob_index;
        if (!new_ent.rs1_rdy && q.wakeup_active && (q.in_rs1_tag == q.wakeup_tag)) begin
            new_ent.rs1_rdy = 1'b1;
            new_ent.rs1_val = q.wakeup_value;
        end
        if (!new_ent.rs2_rdy && q.wakeup_active && (q.in_rs2_tag == q.wakeup_tag)) begin
            new_ent.rs2_rdy = 1'b1;
            new_ent.rs2_val = q.wakeup_value;
        end
    end

    // Next queue image: wakeup snoop, collapse over the issued slot, append
    always_comb begin
        cnt_mid = count_r - {{(CNT_W-1){1'b0}}, issue};
        for (int i = 0; i < DEPTH; i++) begin
            woke[i] = slots[i];
            if (!slots[i].rs1_rdy && q.wakeup_active && (slots[i].rs1_tag == q.wakeup_tag)) begin
                woke[i].rs1_rdy = 1'b1;
                woke[i].rs1_val = q.wakeup_value;
            end
            if (!slots[i].rs2_rdy && q.wakeup_active && (slots[i].rs2_tag == q.wakeup_tag)) begin
                woke[i].rs2_rdy = 1'b1;
                woke[i].rs2_val = q.wakeup_value;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            slots_nxt[i] = woke[i];
        end
        // Slots above the issued one slide down; the top slot keeps stale data
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (issue && (SEL_W'(i) >= sel)) slots_nxt[i] = woke[i + 1];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (accept && (CNT_W'(i) == cnt_mid)) slots_nxt[i] = new_ent;
        end
        count_nxt = cnt_mid + {{(CNT_W-1){1'b0}}, accept};
        if (flush) count_nxt = '0;
    end

    // State register; reset clears contents so idle fu_* outputs read zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= '0;
            for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
        end else begin
            count_r <= count_nxt;
            for (int i = 0; i < DEPTH; i++) slots[i] <= slots_nxt[i];
        end
    end
endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: a scoreboard of expected issue records is
// filled as stimulus is driven and drained by a monitor on every FU issue.
module tb_issue_queue;
    localparam int DEPTH  = 8;
    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [3:0]  alu;
        logic        src;
        logic        lsq;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [5:0]  tag;
        logic [5:0]  rob;
    } rec_t;

    logic clk;
    logic reset;
    logic flush;
    int   errors;
    int   checks;
    rec_t sb[$];

    issue_queue_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

    issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .q     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic rec_t mk(input logic [3:0] alu, input logic src, input logic lsq,
                                input logic [31:0] imm, input logic [31:0] rs1,
                                input logic [31:0] rs2, input logic [5:0] tag,
                                input logic [5:0] rob);
        rec_t r;
        r.alu = alu; r.src = src; r.lsq = lsq; r.imm = imm;
        r.rs1 = rs1; r.rs2 = rs2; r.tag = tag; r.rob = rob;
        return r;
    endfunction

    // Every FU issue must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (bus.fu_write_enable === 1'b1) begin
            rec_t obs;
            obs = mk(bus.fu_ALUControl, bus.fu_ALUSrc, bus.fu_is_for_lsq, bus.fu_imm,
                     bus.fu_rs1_value, bus.fu_rs2_value, bus.fu_tag_to_output,
                     bus.fu_rob_index);
            if (sb.size() == 0) begin
                chk("unexpected_issue", 128'(obs), 128'(0));
            end else begin
                chk("issue_payload", 128'(obs), 128'(sb.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        bus.in_valid      = 1'b0;
        bus.wakeup_active = 1'b0;
    endtask

    task automatic wake(input logic [5:0] tag, input logic [31:0] val);
        bus.wakeup_active = 1'b1;
        bus.wakeup_tag    = tag;
        bus.wakeup_value  = val;
    endtask

    task automatic disp(input logic [3:0] alu, input logic src, input logic lsq,
                        input logic [31:0] imm,
                        input logic r1rdy, input logic [5:0] r1tag, input logic [31:0] r1val,
                        input logic r2rdy, input logic [5:0] r2tag, input logic [31:0] r2val,
                        input logic [5:0] dest, input logic [5:0] rob);
        bus.in_valid      = 1'b1;
        bus.in_ALUControl = alu;
        bus.in_ALUSrc     = src;
        bus.in_is_for_lsq = lsq;
        bus.in_imm        = imm;
        bus.in_rs1_ready  = r1rdy;
        bus.in_rs1_tag    = r1tag;
        bus.in_rs1_value  = r1val;
        bus.in_rs2_ready  = r2rdy;
        bus.in_rs2_tag    = r2tag;
        bus.in_rs2_value  = r2val;
        bus.in_dest_tag   = dest;
        bus.in_rob_index  = rob;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        flush  = 1'b0;
        bus.fu_is_available = 1'b0;
        bus.wakeup_tag      = '0;
        bus.wakeup_value    = '0;
        disp(4'd0, 1'b0, 1'b0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 6'd0, 6'd0);
        idle();
        tick();
        tick();
        // reset state
        settle();
        chk("rst_count", 128'(bus.count), 128'(0));
        chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
        chk("rst_fu_we", 128'(bus.fu_write_enable), 128'(0));
        chk("rst_fu_rs1", 128'(bus.fu_rs1_value), 128'(0));
        reset = 1'b1;
        tick();

        // ready ADD issues the cycle after dispatch
        bus.fu_is_available = 1'b1;
        disp(4'd0, 1'b0, 1'b0, 32'd0, 1'b1, 6'd1, 32'd5, 1'b1, 6'd2, 32'd7, 6'd20, 6'd1);
        sb.push_back(mk(4'd0, 1'b0, 1'b0, 32'd0, 32'd5, 32'd7, 6'd20, 6'd1));
        settle();
        chk("add_no_issue_on_dispatch", 128'(bus.fu_write_enable), 128'(0));
        tick();
        idle();
        settle();
        chk("add_issue", 128'(bus.fu_write_enable), 128'(1));
        chk("add_count_held", 128'(bus.count), 128'(1));
        tick();
        chk("add_count_after", 128'(bus.count), 128'(0));

        // OR waits on tag 12; wakeup two cycles later
        disp(4'd6, 1'b0, 1'b0, 32'd0, 1'b0, 6'd12, 32'd0, 1'b1, 6'd0, 32'd1, 6'd21, 6'd2);
        tick();
        idle();
        settle();
        chk("or_waiting", 128'(bus.fu_write_enable), 128'(0));
        tick();
        wake(6'd12, 32'hA5);
        sb.push_back(mk(4'd6, 1'b0, 1'b0, 32'd0, 32'hA5, 32'd1, 6'd21, 6'd2));
        settle();
        chk("or_not_same_cycle", 128'(bus.fu_write_enable), 128'(0));
        tick();
        idle();
        settle();
        chk("or_issue_next", 128'(bus.fu_write_enable), 128'(1));
        tick();
        chk("or_count_after", 128'(bus.count), 128'(0));

        // dispatch bypass from a same-cycle wakeup
        disp(4'd2, 1'b0, 1'b0, 32'd0, 1'b0, 6'd9, 32'd0, 1'b1, 6'd0, 32'd2, 6'd22, 6'd3);
        wake(6'd9, 32'd3);
        sb.push_back(mk(4'd2, 1'b0, 1'b0, 32'd0, 32'd3, 32'd2, 6'd22, 6'd3));
        tick();
        idle();
        settle();
        chk("bypass_issue", 128'(bus.fu_write_enable), 128'(1));
        tick();

        // immediate rhs ignores rs2 readiness
        disp(4'd3, 1'b1, 1'b1, 32'h1234, 1'b1, 6'd0, 32'd9, 1'b0, 6'd33, 32'd0, 6'd23, 6'd4);
        sb.push_back(mk(4'd3, 1'b1, 1'b1, 32'h1234, 32'd9, 32'd0, 6'd23, 6'd4));
        tick();
        idle();
        settle();
        chk("alusrc_issue", 128'(bus.fu_write_enable), 128'(1));
        tick();

        // dispatch and issue in the same cycle; both operands from one broadcast
        bus.fu_is_available = 1'b0;
        disp(4'd1, 1'b0, 1'b0, 32'd0, 1'b1, 6'd0, 32'd11, 1'b1, 6'd0, 32'd12, 6'd24, 6'd5);
        tick();
        bus.fu_is_available = 1'b1;
        disp(4'd4, 1'b0, 1'b0, 32'd0, 1'b0, 6'd40, 32'd0, 1'b0, 6'd40, 32'd0, 6'd25, 6'd6);
        sb.push_back(mk(4'd1, 1'b0, 1'b0, 32'd0, 32'd11, 32'd12, 6'd24, 6'd5));
        settle();
        chk("dual_issue", 128'(bus.fu_write_enable), 128'(1));
        tick();
        idle();
        settle();
        chk("dual_count_same", 128'(bus.count), 128'(1));
        wake(6'd40, 32'h77);
        sb.push_back(mk(4'd4, 1'b0, 1'b0, 32'd0, 32'h77, 32'h77, 6'd25, 6'd6));
        tick();
        idle();
        settle();
        chk("both_ops_woken", 128'(bus.fu_write_enable), 128'(1));
        tick();
        chk("dual_count_after", 128'(bus.count), 128'(0));

        // fill the queue; the ninth dispatch is dropped
        bus.fu_is_available = 1'b0;
        for (int i = 0; i < 8; i++) begin
            disp(4'(i), 1'b0, 1'b0, 32'd0, 1'b0, 6'(50 + i), 32'd0,
                 1'b1, 6'd0, 32'(i), 6'(10 + i), 6'(i));
            tick();
        end
        idle();
        settle();
        chk("full_count", 128'(bus.count), 128'(8));
        chk("full_in_ready", 128'(bus.in_ready), 128'(0));
        disp(4'd15, 1'b0, 1'b0, 32'd0, 1'b1, 6'd0, 32'd99, 1'b1, 6'd0, 32'd98, 6'd30, 6'd30);
        tick();
        idle();
        settle();
        chk("ninth_dropped", 128'(bus.count), 128'(8));
        wake(6'd52, 32'h102);
        tick();
        wake(6'd55, 32'h105);
        tick();
        idle();
        sb.push_back(mk(4'd2, 1'b0, 1'b0, 32'd0, 32'h102, 32'd2, 6'd12, 6'd2));
        sb.push_back(mk(4'd5, 1'b0, 1'b0, 32'd0, 32'h105, 32'd5, 6'd15, 6'd5));
        bus.fu_is_available = 1'b1;
        settle();
        chk("sel_entry2", 128'(bus.fu_write_enable), 128'(1));
        tick();
        settle();
        chk("sel_entry5", 128'(bus.fu_write_enable), 128'(1));
        chk("count_after_one", 128'(bus.count), 128'(7));
        tick();
        settle();
        chk("count_after_two", 128'(bus.count), 128'(6));
        chk("none_ready", 128'(bus.fu_write_enable), 128'(0));
        // age order survives the collapse
        bus.fu_is_available = 1'b0;
        wake(6'd57, 32'h107);
        tick();
        wake(6'd50, 32'h100);
        tick();
        idle();
        sb.push_back(mk(4'd0, 1'b0, 1'b0, 32'd0, 32'h100, 32'd0, 6'd10, 6'd0));
        sb.push_back(mk(4'd7, 1'b0, 1'b0, 32'd0, 32'h107, 32'd7, 6'd17, 6'd7));
        bus.fu_is_available = 1'b1;
        tick();
        tick();
        settle();
        chk("count_four_left", 128'(bus.count), 128'(4));

        // flush beats dispatch, wakeup and issue
        bus.fu_is_available = 1'b0;
        wake(6'd53, 32'h103);
        tick();
        flush = 1'b1;
        bus.fu_is_available = 1'b1;
        wake(6'd51, 32'h101);
        disp(4'd9, 1'b0, 1'b0, 32'd0, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd1, 6'd31, 6'd31);
        settle();
        chk("flush_no_issue", 128'(bus.fu_write_enable), 128'(0));
        tick();
        flush = 1'b0;
        idle();
        settle();
        chk("flush_count", 128'(bus.count), 128'(0));
        chk("flush_in_ready", 128'(bus.in_ready), 128'(1));
        chk("flush_no_leftover", 128'(bus.fu_write_enable), 128'(0));
        tick();

        // asynchronous reset in the middle of a run
        bus.fu_is_available = 1'b0;
        for (int i = 0; i < 3; i++) begin
            disp(4'd8, 1'b0, 1'b0, 32'd0, 1'b0, 6'(60 + i), 32'd0,
                 1'b1, 6'd0, 32'd4, 6'(i), 6'(i));
            tick();
        end
        idle();
        settle();
        chk("pre_reset_count", 128'(bus.count), 128'(3));
        wake(6'd60, 32'h55);
        tick();
        idle();
        bus.fu_is_available = 1'b1;
        reset = 1'b0;
        settle();
        chk("midrst_count", 128'(bus.count), 128'(0));
        chk("midrst_in_ready", 128'(bus.in_ready), 128'(1));
        chk("midrst_fu_we", 128'(bus.fu_write_enable), 128'(0));
        tick();
        reset = 1'b1;
        settle();
        chk("post_rst_count", 128'(bus.count), 128'(0));
        chk("post_rst_fu_we", 128'(bus.fu_write_enable), 128'(0));
        tick();
        tick();

        chk("scoreboard_drained", 128'(sb.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
